// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - shared types and constants for the core-side DMI request path
//
// Purpose: FSM state encoding, dmistat codes and default bus widths used by
//          dmi_core_req_ctrl and its timeout counter.
// Ports:   none (package)
package dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } dmi_state_e;

    localparam logic [1:0] DMISTAT_OK   = 2'b00;
    localparam logic [1:0] DMISTAT_FAIL = 2'b10;
    localparam logic [1:0] DMISTAT_BUSY = 2'b11;

    // A failure never downgrades an overrun that is already recorded.
    function automatic logic [1:0] dmistat_on_fail(input logic [1:0] cur);
        return (cur == DMISTAT_BUSY) ? DMISTAT_BUSY : DMISTAT_FAIL;
    endfunction

endpackage

// File: rtl/dmi_tmo_cnt.sv
// rtl/dmi_tmo_cnt.sv - saturating transaction timeout counter
//
// Purpose: counts cycles while a DMI transaction is in flight and flags expiry.
// Ports:
//   clk       in   core clock
//   rst_n     in   asynchronous active-low reset
//   clr_i     in   restart the count at zero (start of a transaction)
//   en_i      in   count this cycle
//   expire_o  out  this is the last allowed cycle of the transaction
module dmi_tmo_cnt #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_LAST = CNT_MAX - {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry fires in the cycle whose increment reaches all-ones, so the
    // transaction gets 2**W-1 cycles. A count already at all-ones (handshake
    // taken in the expiry cycle) keeps expiring until the transaction ends.
    assign expire_o = en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/dmi_core_req_ctrl.sv
// rtl/dmi_core_req_ctrl.sv - core-side DMI request controller
//
// Purpose: turns synchronizer reg_en pulses into one valid/ready request to the
//          debug module, waits for the response, holds read data and a sticky
//          dmistat code for the TAP.
// Ports:
//   clk, rst_n                         core clock, asynchronous active-low reset
//   reg_en, reg_wr_en                  request pulse and write qualifier
//   jtag_addr, jtag_wdata              quasi-static JTAG address / write data
//   dmireset                           pulse: clear sticky dmistat
//   dmi_req_valid/ready/write/addr/wdata   request channel to debug module
//   dmi_rsp_valid/err/rdata            response channel from debug module
//   rd_data                            last successful read data
//   dmistat                            00 ok, 10 failed, 11 busy/overrun
//   busy                               transaction in flight
module dmi_core_req_ctrl
    import dmi_pkg::*;
#(
    parameter int ADDR_W = DMI_ADDR_W,
    parameter int DATA_W = DMI_DATA_W,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_en,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    input  logic              dmireset,
    output logic              dmi_req_valid,
    input  logic              dmi_req_ready,
    output logic              dmi_req_write,
    output logic [ADDR_W-1:0] dmi_req_addr,
    output logic [DATA_W-1:0] dmi_req_wdata,
    input  logic              dmi_rsp_valid,
    input  logic              dmi_rsp_err,
    input  logic [DATA_W-1:0] dmi_rsp_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        dmistat,
    output logic              busy
);

    dmi_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        stat_q, stat_d;

    logic tmo_clr;
    logic tmo_expire;
    logic set_fail;
    logic set_busy;

    dmi_tmo_cnt #(
        .W(TMO_W)
    ) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmo_clr),
        .en_i     (state_q != IDLE),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        rd_data_d = rd_data_q;
        tmo_clr   = 1'b0;
        set_fail  = 1'b0;

        case (state_q)
            IDLE: begin
                // A pending error/overrun blocks new requests until dmireset.
                if (reg_en && (stat_q == DMISTAT_OK)) begin
                    state_d = REQ;
                    addr_d  = jtag_addr;
                    wdata_d = jtag_wdata;
                    write_d = reg_wr_en;
                    tmo_clr = 1'b1;
                end
            end
            REQ: begin
                // Handshake wins over a timeout in the same cycle.
                if (dmi_req_ready) begin
                    state_d = WAIT;
                end else if (tmo_expire) begin
                    state_d  = IDLE;
                    set_fail = 1'b1;
                end
            end
            WAIT: begin
                if (dmi_rsp_valid) begin
                    state_d = IDLE;
                    if (dmi_rsp_err) begin
                        set_fail = 1'b1;
                    end else if (!write_q) begin
                        rd_data_d = dmi_rsp_rdata;
                    end
                end else if (tmo_expire) begin
                    state_d  = IDLE;
                    set_fail = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // reg_en during a transaction is an overrun; it never restarts the FSM.
        set_busy = reg_en && (state_q != IDLE);

        stat_d = stat_q;
        if (set_busy) begin
            stat_d = DMISTAT_BUSY;
        end else if (set_fail) begin
            stat_d = dmistat_on_fail(stat_q);
        end else if (dmireset) begin
            stat_d = DMISTAT_OK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rd_data_q <= '0;
            stat_q    <= DMISTAT_OK;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            rd_data_q <= rd_data_d;
            stat_q    <= stat_d;
        end
    end

    // Decoded straight from the state register so reset drops valid at once.
    assign dmi_req_valid = (state_q == REQ);
    assign busy          = (state_q != IDLE);
    assign dmi_req_write = write_q;
    assign dmi_req_addr  = addr_q;
    assign dmi_req_wdata = wdata_q;
    assign rd_data       = rd_data_q;
    assign dmistat       = stat_q;

endmodule

// File: tb/tb_dmi_core_req_ctrl.sv
// tb/tb_dmi_core_req_ctrl.sv - scoreboard bench for dmi_core_req_ctrl
module tb_dmi_core_req_ctrl;
    import dmi_pkg::*;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int EXP_C = (1 << TW) - 1;

    logic          clk;
    logic          rst_n;
    logic          reg_en;
    logic          reg_wr_en;
    logic [AW-1:0] jtag_addr;
    logic [DW-1:0] jtag_wdata;
    logic          dmireset;
    logic          dmi_req_valid;
    logic          dmi_req_ready;
    logic          dmi_req_write;
    logic [AW-1:0] dmi_req_addr;
    logic [DW-1:0] dmi_req_wdata;
    logic          dmi_rsp_valid;
    logic          dmi_rsp_err;
    logic [DW-1:0] dmi_rsp_rdata;
    logic [DW-1:0] rd_data;
    logic [1:0]    dmistat;
    logic          busy;

    dmi_core_req_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TMO_W (TW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reg_en        (reg_en),
        .reg_wr_en     (reg_wr_en),
        .jtag_addr     (jtag_addr),
        .jtag_wdata    (jtag_wdata),
        .dmireset      (dmireset),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_ready (dmi_req_ready),
        .dmi_req_write (dmi_req_write),
        .dmi_req_addr  (dmi_req_addr),
        .dmi_req_wdata (dmi_req_wdata),
        .dmi_rsp_valid (dmi_rsp_valid),
        .dmi_rsp_err   (dmi_rsp_err),
        .dmi_rsp_rdata (dmi_rsp_rdata),
        .rd_data       (rd_data),
        .dmistat       (dmistat),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            vcyc;
    } req_t;

    typedef struct {
        logic [DW-1:0] rd;
        logic [1:0]    stat;
        int            end_cyc;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    logic [1:0]    m_stat = DMISTAT_OK;
    logic [DW-1:0] m_rd   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    bit    valid_prev = 1'b0;
    bit    busy_prev  = 1'b0;
    int    vcnt       = 0;
    done_t mon_d;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (dmi_req_valid) begin
                    check("req_expected", {63'd0, req_q.size() > 0}, 64'd1);
                    if (req_q.size() > 0) begin
                        check("req_write", dmi_req_write, req_q[0].wr);
                        check("req_addr", dmi_req_addr, req_q[0].addr);
                        check("req_wdata", dmi_req_wdata, req_q[0].wdata);
                    end
                    vcnt++;
                end
                if (valid_prev && !dmi_req_valid && req_q.size() > 0) begin
                    check("req_valid_cycles", vcnt, req_q[0].vcyc);
                    void'(req_q.pop_front());
                end
                if (busy_prev && !busy) begin
                    check("done_expected", {63'd0, done_q.size() > 0}, 64'd1);
                    if (done_q.size() > 0) begin
                        mon_d = done_q.pop_front();
                        check("done_rd_data", rd_data, mon_d.rd);
                        check("done_dmistat", dmistat, mon_d.stat);
                        check("done_cycle", cyc, mon_d.end_cyc);
                    end
                end
            end
            if (!dmi_req_valid) vcnt = 0;
            valid_prev = dmi_req_valid;
            busy_prev  = busy;
        end
    end

    // One JTAG request plus the debug-module side, scheduled in cycles after the
    // edge that samples reg_en (cycle 1 is the first cycle valid may be high).
    //   rd:    ready comes in cycle rd+1
    //   rsp:   response comes rsp cycles after the handshake cycle
    //   ovr_c: cycle of an extra reg_en pulse (0 = none)
    //   rst_c: cycle of a dmireset pulse (0 = none)
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int rd, input int rsp, input bit err, input logic [DW-1:0] rdata,
                           input int ovr_c, input int rst_c);
        int         hs_c, rsp_c, end_c, last_c, cyc0;
        bit         issue, hs_ok, rsp_ok, fail;
        logic [1:0] st;
        req_t       r;
        done_t      d;

        issue = (m_stat == DMISTAT_OK);
        jtag_addr  = addr;
        jtag_wdata = wdata;
        reg_wr_en  = wr;
        reg_en     = 1'b1;
        @(posedge clk);
        #1;
        reg_en     = 1'b0;
        reg_wr_en  = 1'b0;
        jtag_addr  = AW'($urandom);
        jtag_wdata = $urandom;
        cyc0       = cyc;

        hs_c  = rd + 1;
        rsp_c = hs_c + rsp;
        end_c = 0;
        if (issue) begin
            hs_ok  = (hs_c <= EXP_C);
            rsp_ok = hs_ok && (rsp_c <= EXP_C);
            end_c  = rsp_ok ? rsp_c : EXP_C;
            fail   = !rsp_ok || err;
            r.wr = wr; r.addr = addr; r.wdata = wdata;
            r.vcyc = hs_ok ? hs_c : EXP_C;
            req_q.push_back(r);
            st = m_stat;
            for (int c = 1; c <= end_c; c++) begin
                if (c == ovr_c) st = DMISTAT_BUSY;
                else if (c == end_c && fail) st = (st == DMISTAT_BUSY) ? DMISTAT_BUSY : DMISTAT_FAIL;
                else if (c == rst_c) st = DMISTAT_OK;
            end
            if (rsp_ok && !err && !wr) m_rd = rdata;
            m_stat = st;
            d.rd = m_rd; d.stat = m_stat; d.end_cyc = cyc0 + end_c;
            done_q.push_back(d);
        end

        last_c = ((rsp_c > end_c) ? rsp_c : end_c) + 2;
        for (int c = 1; c <= last_c; c++) begin
            dmi_req_ready = (c == hs_c);
            dmi_rsp_valid = (c == rsp_c);
            dmi_rsp_err   = (c == rsp_c) ? err : 1'($urandom);
            dmi_rsp_rdata = (c == rsp_c) ? rdata : $urandom;
            reg_en        = issue && (c == ovr_c);
            reg_wr_en     = 1'($urandom);
            dmireset      = issue && (c == rst_c);
            @(posedge clk);
            #1;
        end
        dmi_req_ready = 1'b0;
        dmi_rsp_valid = 1'b0;
        reg_en        = 1'b0;
        reg_wr_en     = 1'b0;
        dmireset      = 1'b0;

        if (!issue) begin
            check("drop_dmistat", dmistat, m_stat);
            check("drop_busy", busy, 1'b0);
        end
    endtask

    task automatic do_dmireset();
        dmireset = 1'b1;
        @(posedge clk);
        #1;
        dmireset = 1'b0;
        m_stat   = DMISTAT_OK;
        check("dmireset_clr", dmistat, DMISTAT_OK);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd, rsp, cap;
        bit err;

        rst_n = 1'b0; reg_en = 1'b0; reg_wr_en = 1'b0; jtag_addr = '0; jtag_wdata = '0;
        dmireset = 1'b0; dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_err = 1'b0;
        dmi_rsp_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", dmi_req_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_dmistat", dmistat, 2'b00);
        check("reset_rd_data", rd_data, '0);
        check("reset_addr", dmi_req_addr, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Read, ready with valid, response two cycles later.
        run_txn(1'b0, 7'h11, 32'h0, 0, 2, 1'b0, 32'hDEADBEEF, 0, 0);
        // Write with ready held off for five cycles.
        run_txn(1'b1, 7'h10, 32'h1, 5, 1, 1'b0, 32'h12345678, 0, 0);
        // Error, then a blocked request, then dmireset and a good read.
        run_txn(1'b0, 7'h05, 32'h0, 1, 2, 1'b1, 32'hBAD0BAD0, 0, 0);
        run_txn(1'b0, 7'h06, 32'h0, 0, 1, 1'b0, 32'h11111111, 0, 0);
        do_dmireset();
        run_txn(1'b0, 7'h07, 32'h0, 2, 1, 1'b0, 32'hCAFEF00D, 0, 0);
        // Overrun while waiting for the response, then an error that must not downgrade it.
        run_txn(1'b0, 7'h08, 32'h0, 1, 4, 1'b1, 32'h0, 3, 0);
        do_dmireset();
        // Timeouts in REQ and WAIT, then a response in the expiry cycle.
        run_txn(1'b0, 7'h09, 32'h0, 20, 1, 1'b0, 32'h0, 0, 0);
        do_dmireset();
        run_txn(1'b0, 7'h0A, 32'h0, 2, 20, 1'b0, 32'h0, 0, 0);
        do_dmireset();
        run_txn(1'b0, 7'h0B, 32'h0, 4, 10, 1'b0, 32'hA5A5A5A5, 0, 0);

        // Asynchronous reset while the request is outstanding.
        mon_en = 1'b0;
        jtag_addr = 7'h22; jtag_wdata = 32'h55AA55AA; reg_wr_en = 1'b1; reg_en = 1'b1;
        @(posedge clk);
        #1;
        reg_en = 1'b0; reg_wr_en = 1'b0;
        check("pre_reset_valid", dmi_req_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", dmi_req_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_write", dmi_req_write, 1'b0);
        check("midrst_addr", dmi_req_addr, '0);
        check("midrst_wdata", dmi_req_wdata, '0);
        check("midrst_rd_data", rd_data, '0);
        check("midrst_dmistat", dmistat, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_stat = DMISTAT_OK; m_rd = '0;
        req_q.delete(); done_q.delete();
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // dmireset in the same cycle as an error response: the error wins.
        run_txn(1'b0, 7'h0C, 32'h0, 0, 3, 1'b1, 32'h0, 0, 4);
        do_dmireset();

        for (int i = 0; i < 40; i++) begin
            if (m_stat != DMISTAT_OK && ($urandom % 2) == 0) do_dmireset();
            rd  = (($urandom % 6) == 0) ? 15 + int'($urandom % 4) : int'($urandom % 7);
            rsp = 1 + int'($urandom % 8);
            err = (($urandom % 5) == 0);
            cap = ((rd + 1) < EXP_C) ? rd + 1 : EXP_C;
            run_txn(1'($urandom), AW'($urandom), $urandom, rd, rsp, err, $urandom,
                    (($urandom % 6) == 0) ? 1 + int'($urandom % cap) : 0,
                    (($urandom % 6) == 0) ? 1 + int'($urandom % cap) : 0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb_req_drained", req_q.size(), 0);
        check("sb_done_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
